// File: rtl/keccak_arbiter.sv
// Purpose : arbitrates two message requesters (a, b) onto one Keccak/SHA-3 hash core and latches the digest.
// Latency : request seen in IDLE -> CLR (core reset) -> FEED, so the first word can be accepted 2 cycles later.
// Backpress: word accept = valid of granted requester & ~core_buffer_full; ack mirrors core_in_ready combinationally.
//
// Ports:
//   clk, reset_n                      sole clock, asynchronous active-low reset
//   req_X/word_X/valid_X/last_X/bytes_X  per-requester job request and message word stream (X = a, b)
//   ack_X, done_X                     word accepted this cycle / job complete (one-cycle pulse)
//   core_*                            hash-core side: reset, word stream, byte count, digest handshake
//   result, result_id, error          latched digest, its owner (0=a, 1=b), watchdog timeout pulse
//
// Build option: define KECCAK_ARB_WATCHDOG_EN to abort a WAIT that exceeds TIMEOUT_CYC cycles.
module keccak_arbiter #(
   parameter int D           = 512,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req_a,
   input  logic [63:0]  word_a,
   input  logic         valid_a,
   input  logic         last_a,
   input  logic [2:0]   bytes_a,
   output logic         ack_a,
   output logic         done_a,
   input  logic         req_b,
   input  logic [63:0]  word_b,
   input  logic         valid_b,
   input  logic         last_b,
   input  logic [2:0]   bytes_b,
   output logic         ack_b,
   output logic         done_b,
   output logic         core_reset,
   output logic [63:0]  core_in,
   output logic         core_in_ready,
   output logic         core_is_last,
   output logic [2:0]   core_byte_num,
   input  logic         core_buffer_full,
   input  logic [D-1:0] core_out,
   input  logic         core_out_ready,
   output logic [D-1:0] result,
   output logic         result_id,
   output logic         error
);

   typedef enum logic [2:0] {IDLE, CLR, FEED, WAIT, DONE} state_t;

   state_t state, state_nxt;
   logic   grant, grant_nxt;            // 0 = a, 1 = b
   logic   last_grant, last_grant_nxt;  // owner of the last finished/aborted job
   logic   capture;
   logic   wd_expire;
   logic   sel_valid, sel_last;
   logic [2:0] sel_bytes;

   // granted requester's word stream, steered straight to the core
   assign sel_valid = grant ? valid_b : valid_a;
   assign sel_last  = grant ? last_b  : last_a;
   assign sel_bytes = grant ? bytes_b : bytes_a;
   assign core_in   = grant ? word_b  : word_a;

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      capture        = 1'b0;
      core_in_ready  = 1'b0;
      case (state)
         IDLE: begin
            if (req_a || req_b) begin
               // on contention the requester not served last wins
               grant_nxt = (req_a && req_b) ? ~last_grant : req_b;
               state_nxt = CLR;
            end
         end
         CLR:  state_nxt = FEED;
         FEED: begin
            core_in_ready = sel_valid & ~core_buffer_full;
            if (core_in_ready && sel_last) state_nxt = WAIT;
         end
         WAIT: begin
            if (core_out_ready) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end else if (wd_expire) begin
               last_grant_nxt = grant;
               state_nxt      = IDLE;
            end
         end
         DONE: begin
            last_grant_nxt = grant;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ack_a         = core_in_ready & ~grant;
   assign ack_b         = core_in_ready &  grant;
   assign core_is_last  = core_in_ready & sel_last;
   assign core_byte_num = core_is_last ? sel_bytes : 3'd0;
   assign done_a        = (state == DONE) & ~grant;
   assign done_b        = (state == DONE) &  grant;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         core_reset <= 1'b1;
         result     <= '0;
         result_id  <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         // registered so the core sees a glitch-free reset that tracks the state
         core_reset <= (state_nxt == IDLE) || (state_nxt == CLR) || (state_nxt == DONE);
         if (capture) begin
            result    <= core_out;
            result_id <= grant;
         end
      end
   end

`ifdef KECCAK_ARB_WATCHDOG_EN
   localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CW-1:0] wd_cnt;
   logic          err_q;

   // counter is held at zero outside WAIT, so it starts from zero on every WAIT entry;
   // it reads TIMEOUT_CYC-1 in the TIMEOUT_CYC-th WAIT cycle
   assign wd_expire = (state == WAIT) && !core_out_ready && (wd_cnt == CW'(TIMEOUT_CYC - 1));
   assign error     = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q  <= wd_expire;
         wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
      end
   end
`else
   assign wd_expire = 1'b0;
   assign error     = 1'b0;
`endif

endmodule

// File: doc/keccak_arbiter.md
KECCAK_ARBITER -- requirements
Module: keccak_arbiter

Interface
REQ-001 SHALL have parameter D, default 512, meaning digest width in bits, equal to the attached hash core's output length.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, meaning the WAIT-state cycle limit; it is used only when the watchdog is compiled in (REQ-024).
REQ-003 SHALL have ports: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have per-requester ports, X in {a,b}: req_X in 1 job request; word_X in 64 message word; valid_X in 1 word valid; last_X in 1 final word; bytes_X in 3 valid bytes of final word (0 = none); ack_X out 1 word accepted; done_X out 1 job complete.
REQ-005 SHALL have core-side ports: core_reset out 1 active-high core reset; core_in out 64; core_in_ready out 1; core_is_last out 1; core_byte_num out 3; core_buffer_full in 1; core_out in D; core_out_ready in 1.
REQ-006 SHALL have result ports: result out D latched digest; result_id out 1 owner (0=a, 1=b); error out 1 timeout pulse.

Function
REQ-007 SHALL implement FSM states IDLE, CLR, FEED, WAIT, DONE.
REQ-008 IDLE: on any req_X high -> CLR, grant registered at that edge.
REQ-009 Both requesting: grant the requester not served last; last_grant resets to b, so a wins first contention.
REQ-010 CLR lasts exactly one cycle with core_reset high, then -> FEED.
REQ-011 core_reset SHALL be a registered output: high in IDLE, CLR and DONE; low in FEED and WAIT.
REQ-012 FEED: core_in_ready = valid_G & ~core_buffer_full; ack_G equals core_in_ready in the same cycle; core_in = word_G, driven combinationally from the granted requester G.
REQ-013 core_is_last = core_in_ready & last_G; core_byte_num = bytes_G when core_is_last, else 0.
REQ-014 The non-granted requester's ack SHALL stay 0.
REQ-015 An accepted word with last_G high -> WAIT; no further words accepted for the job.
REQ-016 WAIT: core_in_ready=0; on core_out_ready high, latch core_out into result and G into result_id, then -> DONE.
REQ-017 DONE lasts one cycle: done_G=1, last_grant<=G, then -> IDLE.
REQ-018 result and result_id SHALL hold until the next DONE.
REQ-019 req_X is ignored after grant until DONE; requesters hold req until done.
REQ-020 A requester still requesting in IDLE after DONE is re-granted only if the other is not requesting.
REQ-021 Minimum latency, IDLE request to first possible ack: 2 cycles (CLR, then FEED).

Reset
REQ-022 reset_n low, any state, asynchronously -> IDLE.
REQ-023 During and after reset: core_reset=1; ack_a=ack_b=done_a=done_b=core_in_ready=core_is_last=error=0; core_byte_num=0; result=0; result_id=0; last_grant=b. A mid-job reset drops the job with no done.

Configuration
REQ-024 Macro KECCAK_ARB_WATCHDOG_EN defined: an 8+ bit counter clears on WAIT entry; after TIMEOUT_CYC cycles in WAIT without core_out_ready -> one-cycle error=1 and -> IDLE; no done, result unchanged, last_grant<=G.
REQ-025 Macro undefined: no counter, error tied 0, WAIT held indefinitely.

Verification
REQ-026 Empty message on a: req_a=1, valid_a=1, last_a=1, bytes_a=0 -> one ack_a; done_a once; result equals NIST SHA3-512("") a69f73cc...281dcd26 in core byte order; result_id=0.
REQ-027 req_a and req_b high same cycle after reset -> a served first, then b with no idle gap beyond IDLE+CLR; result_id 0 then 1.
REQ-028 core_buffer_full held high 5 cycles mid-message -> ack and core_in_ready both 0 those cycles; no word lost or duplicated; digest matches model.
REQ-029 reset_n pulsed low during FEED after 3 acks -> all outputs at reset values; next job on b completes with correct digest.
REQ-030 KECCAK_ARB_WATCHDOG_EN, TIMEOUT_CYC=16, core_out_ready stubbed low -> error pulses once, 16 cycles after WAIT entry; FSM returns to IDLE; done never asserted.
REQ-031 Multi-word message of 9 full words plus last with bytes=3 on b -> exactly 10 acks; core_byte_num=3 only on the final word.
